div_result_bcd: RTL and testbench

// - Downstream stage of the restoring divider. Captures each new Quotient/Remainder pair

---
 rtl/div_pkg.sv | 25 ++
 rtl/bcd_dabble_step.sv | 27 ++
 rtl/div_result_bcd.sv | 155 +++++++++++++++
 tb/tb_div_result_bcd.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared types and elaboration helpers for the divider result path.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CONVERT,
        HOLD
    } bcd_state_t;

    // Smallest number of decimal digits able to represent 2**w-1.
    function automatic int unsigned digits_for_width(input int unsigned w);
        longint unsigned max_val;
        longint unsigned limit;
        int unsigned     digits;
        max_val = (64'd1 << w) - 64'd1;
        limit   = 64'd10;
        digits  = 1;
        while (limit <= max_val) begin
            limit  = limit * 64'd10;
            digits = digits + 1;
        end
        return digits;
    endfunction

endpackage

// File: rtl/bcd_dabble_step.sv
// One double-dabble step: add 3 to every digit >= 5, then shift left taking msb_i in.
module bcd_dabble_step #(
    parameter int unsigned D = 2
) (
    input  logic [4*D-1:0] bcd_i,
    input  logic           msb_i,
    output logic [4*D-1:0] bcd_o
);

    logic [4*D-1:0] adj;
    // Top bit of the adjusted value is always 0 when D is wide enough for the operand.
    logic           unused_adj_msb;

    // Per-digit add-3 correction followed by the one-bit shift.
    always_comb begin
        adj = bcd_i;
        for (int i = 0; i < int'(D); i++) begin
            if (bcd_i[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = bcd_i[4*i +: 4] + 4'd3;
            end
        end
        bcd_o = {adj[4*D-2:0], msb_i};
    end

    assign unused_adj_msb = adj[4*D-1];

endmodule

// File: rtl/div_result_bcd.sv
// Captures divider results on a ResultValid rising edge and converts quotient and
// remainder to packed BCD in W cycles, then holds them on a valid/ready handshake.
module div_result_bcd
    import div_pkg::*;
#(
    parameter int unsigned W = 4,
    parameter int unsigned D = 2
) (
    input  logic           Clock,
    input  logic           Resetn,
    input  logic           ResultValid,
    input  logic [W-1:0]   Quotient,
    input  logic [W-1:0]   Remainder,
    input  logic           OutReady,
    input  logic           ClearErr,
    output logic [4*D-1:0] QuoBCD,
    output logic [4*D-1:0] RemBCD,
    output logic           BcdValid,
    output logic           Busy,
    output logic           Overrun
);

    localparam int unsigned CntW = $clog2(W + 1);
    localparam logic [CntW-1:0] LastStep = CntW'(W - 1);

    if (D < digits_for_width(W)) begin : g_bad_digits
        $error("div_result_bcd: D=%0d digits cannot hold 2**%0d-1", D, W);
    end

    bcd_state_t     state_q;
    logic [CntW-1:0] cnt_q;
    logic [W-1:0]   quo_bin_q;
    logic [W-1:0]   rem_bin_q;
    logic [4*D-1:0] quo_bcd_q;
    logic [4*D-1:0] rem_bcd_q;
    logic [4*D-1:0] quo_bcd_step;
    logic [4*D-1:0] rem_bcd_step;
    logic           valid_q;
    logic           busy_q;
    logic           rv_q;
    logic           overrun_q;
    logic           cap;
    logic           drop;

    bcd_dabble_step #(
        .D (D)
    ) u_quo_step (
        .bcd_i (quo_bcd_q),
        .msb_i (quo_bin_q[W-1]),
        .bcd_o (quo_bcd_step)
    );

    bcd_dabble_step #(
        .D (D)
    ) u_rem_step (
        .bcd_i (rem_bcd_q),
        .msb_i (rem_bin_q[W-1]),
        .bcd_o (rem_bcd_step)
    );

    // Rising edge of ResultValid; a result arriving while busy or stalled is lost.
    always_comb begin
        cap  = ResultValid & ~rv_q;
        drop = cap & ((state_q == CONVERT) | ((state_q == HOLD) & ~OutReady));
    end

    // Edge-detect register; resets high so a level already up never looks like an edge.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            rv_q <= 1'b1;
        end else begin
            rv_q <= ResultValid;
        end
    end

    // Sticky drop flag; a new drop beats a simultaneous clear.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            overrun_q <= 1'b0;
        end else if (drop) begin
            overrun_q <= 1'b1;
        end else if (ClearErr) begin
            overrun_q <= 1'b0;
        end
    end

    // Conversion FSM with step counter, shift registers and registered status outputs.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            quo_bin_q <= '0;
            rem_bin_q <= '0;
            quo_bcd_q <= '0;
            rem_bcd_q <= '0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cap) begin
                        quo_bin_q <= Quotient;
                        rem_bin_q <= Remainder;
                        quo_bcd_q <= '0;
                        rem_bcd_q <= '0;
                        cnt_q     <= '0;
                        busy_q    <= 1'b1;
                        state_q   <= CONVERT;
                    end
                end
                CONVERT: begin
                    quo_bcd_q <= quo_bcd_step;
                    rem_bcd_q <= rem_bcd_step;
                    quo_bin_q <= quo_bin_q << 1;
                    rem_bin_q <= rem_bin_q << 1;
                    cnt_q     <= cnt_q + CntW'(1);
                    if (cnt_q == LastStep) begin
                        busy_q  <= 1'b0;
                        valid_q <= 1'b1;
                        state_q <= HOLD;
                    end
                end
                HOLD: begin
                    if (OutReady) begin
                        valid_q <= 1'b0;
                        if (cap) begin
                            // Back-to-back: accept the new result without an idle bubble.
                            quo_bin_q <= Quotient;
                            rem_bin_q <= Remainder;
                            quo_bcd_q <= '0;
                            rem_bcd_q <= '0;
                            cnt_q     <= '0;
                            busy_q    <= 1'b1;
                            state_q   <= CONVERT;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: begin
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign QuoBCD   = quo_bcd_q;
    assign RemBCD   = rem_bcd_q;
    assign BcdValid = valid_q;
    assign Busy     = busy_q;
    assign Overrun  = overrun_q;

endmodule

// File: tb/tb_div_result_bcd.sv
// Scoreboard bench for div_result_bcd at W=4/D=2 and W=8/D=3.
module tb_div_result_bcd;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstn;
    logic        clr;
    logic        rv4, ordy4;
    logic [3:0]  q4, r4;
    logic [7:0]  quo4, rem4;
    logic        valid4, busy4, ovr4;
    logic        rv8, ordy8;
    logic [7:0]  q8, r8;
    logic [11:0] quo8, rem8;
    logic        valid8, busy8, ovr8;

    int vectors = 0;
    int miscompares = 0;

    logic [15:0] exp4_q[$];
    logic [23:0] exp8_q[$];

    div_result_bcd #(.W(4), .D(2)) dut4 (
        .Clock       (clk),
        .Resetn      (rstn),
        .ResultValid (rv4),
        .Quotient    (q4),
        .Remainder   (r4),
        .OutReady    (ordy4),
        .ClearErr    (clr),
        .QuoBCD      (quo4),
        .RemBCD      (rem4),
        .BcdValid    (valid4),
        .Busy        (busy4),
        .Overrun     (ovr4)
    );

    div_result_bcd #(.W(8), .D(3)) dut8 (
        .Clock       (clk),
        .Resetn      (rstn),
        .ResultValid (rv8),
        .Quotient    (q8),
        .Remainder   (r8),
        .OutReady    (ordy8),
        .ClearErr    (clr),
        .QuoBCD      (quo8),
        .RemBCD      (rem8),
        .BcdValid    (valid8),
        .Busy        (busy8),
        .Overrun     (ovr8)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: a handshake completes on the coming posedge when valid and ready are both high.
    always @(negedge clk) begin
        if (rstn === 1'b1 && valid4 === 1'b1 && ordy4 === 1'b1) begin
            if (exp4_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL dut4 unexpected result: got %h/%h, expected none", quo4, rem4);
            end else begin
                check("dut4 result", {16'h0, quo4, rem4}, {16'h0, exp4_q.pop_front()});
            end
        end
        if (rstn === 1'b1 && valid8 === 1'b1 && ordy8 === 1'b1) begin
            if (exp8_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL dut8 unexpected result: got %h/%h, expected none", quo8, rem8);
            end else begin
                check("dut8 result", {8'h0, quo8, rem8}, {8'h0, exp8_q.pop_front()});
            end
        end
    end

    // Drop ResultValid for one cycle, then raise it with new operands.
    task automatic issue4(input logic [3:0] q, input logic [3:0] r, input logic [15:0] exp,
                          input bit push);
        rv4 = 1'b0;
        tick();
        q4  = q;
        r4  = r;
        rv4 = 1'b1;
        if (push) exp4_q.push_back(exp);
    endtask

    task automatic wait_valid4();
        int n = 0;
        while (valid4 !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        if (valid4 !== 1'b1) begin
            vectors++;
            miscompares++;
            $display("FAIL dut4 valid timeout: BcdValid=%b, expected 1", valid4);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL global timeout: simulation still running, expected finish");
        $fatal(1);
    end

    initial begin
        rstn = 1'b0; clr = 1'b0;
        rv4 = 1'b0; ordy4 = 1'b0; q4 = '0; r4 = '0;
        rv8 = 1'b0; ordy8 = 1'b1; q8 = '0; r8 = '0;
        repeat (2) tick();
        check("reset quo4", quo4, 0);
        check("reset rem4", rem4, 0);
        check("reset valid4", valid4, 0);
        check("reset busy4", busy4, 0);
        check("reset ovr4", ovr4, 0);
        check("reset quo8", quo8, 0);
        rstn = 1'b1;
        tick();

        // 3/1 with latency check, consumer stalled.
        issue4(4'd3, 4'd1, 16'h0301, 1'b1);
        tick();
        check("t0 busy4", busy4, 1);
        repeat (3) tick();
        check("latency-1 valid4", valid4, 0);
        tick();
        check("latency valid4", valid4, 1);
        check("hold quo4 3", quo4, 8'h03);
        check("hold rem4 1", rem4, 8'h01);
        ordy4 = 1'b1;
        tick();
        check("after accept valid4", valid4, 0);

        // 15/0 with ready held: one valid cycle, then idle keeps digits.
        issue4(4'd15, 4'd0, 16'h1500, 1'b1);
        wait_valid4();
        tick();
        check("one-cycle valid4", valid4, 0);
        check("idle busy4", busy4, 0);
        check("idle keeps quo4", quo4, 8'h15);
        check("idle keeps rem4", rem4, 8'h00);

        // Stall in HOLD, drop a result, set-wins, then clear.
        ordy4 = 1'b0;
        issue4(4'd9, 4'd2, 16'h0902, 1'b1);
        wait_valid4();
        issue4(4'd7, 4'd7, 16'h0, 1'b0);
        tick();
        check("drop ovr4", ovr4, 1);
        check("drop valid4", valid4, 1);
        check("drop quo4 kept", quo4, 8'h09);
        check("drop rem4 kept", rem4, 8'h02);
        issue4(4'd5, 4'd5, 16'h0, 1'b0);
        clr = 1'b1;
        tick();
        check("set wins ovr4", ovr4, 1);
        tick();
        check("clear ovr4", ovr4, 0);
        clr = 1'b0;
        ordy4 = 1'b1;
        tick();
        check("stall release valid4", valid4, 0);

        // Accept and capture in the same HOLD cycle.
        ordy4 = 1'b0;
        issue4(4'd12, 4'd5, 16'h1205, 1'b1);
        wait_valid4();
        rv4 = 1'b0;
        tick();
        q4 = 4'd6; r4 = 4'd3; rv4 = 1'b1; ordy4 = 1'b1;
        exp4_q.push_back(16'h0603);
        tick();
        check("b2b busy4", busy4, 1);
        check("b2b valid4", valid4, 0);
        check("b2b ovr4", ovr4, 0);
        wait_valid4();
        tick();

        // Drop during CONVERT, then asynchronous reset mid-conversion.
        issue4(4'd8, 4'd4, 16'h0804, 1'b1);
        tick();
        rv4 = 1'b0;
        tick();
        rv4 = 1'b1;
        tick();
        check("convert drop ovr4", ovr4, 1);
        check("convert busy4", busy4, 1);
        check("intermediate quo4", quo4, 8'h02);
        rstn = 1'b0;
        #1;
        exp4_q.delete();
        check("async quo4", quo4, 0);
        check("async rem4", rem4, 0);
        check("async busy4", busy4, 0);
        check("async ovr4", ovr4, 0);
        #2;
        rstn = 1'b1;
        tick();
        tick();
        check("no retrigger busy4", busy4, 0);
        check("no retrigger valid4", valid4, 0);
        issue4(4'd10, 4'd11, 16'h1011, 1'b1);
        wait_valid4();
        tick();

        // W=8, D=3: 255/9 in 8 cycles.
        rv8 = 1'b0;
        tick();
        q8 = 8'd255; r8 = 8'd9; rv8 = 1'b1;
        exp8_q.push_back(24'h255009);
        tick();
        repeat (7) tick();
        check("dut8 latency-1 valid", valid8, 0);
        tick();
        check("dut8 valid", valid8, 1);
        check("dut8 quo", quo8, 12'h255);
        check("dut8 rem", rem8, 12'h009);
        tick();
        tick();

        check("dut4 queue drained", exp4_q.size(), 0);
        check("dut8 queue drained", exp8_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
